ss_scan_decoder: RTL and testbench



---
 rtl/wallclock_pkg.sv | 39 +++
 rtl/ss_scan_decoder_if.sv | 8 +
 rtl/seg7_to_bcd.sv | 28 ++
 rtl/ss_scan_decoder.sv | 199 +++++++++++++++++++
 tb/tb_ss_scan_decoder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wallclock_pkg.sv
// rtl/wallclock_pkg.sv - shared glyph, digit-index, FSM state and time-limit definitions
package wallclock_pkg;

    // Active-low a..g in bits 6:0; bit 7 (dp) is off in every constant
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;

    localparam logic [1:0] DIG_M1 = 2'd0;
    localparam logic [1:0] DIG_M2 = 2'd1;
    localparam logic [1:0] DIG_H1 = 2'd2;
    localparam logic [1:0] DIG_H2 = 2'd3;

    typedef enum logic [1:0] {
        S_WAIT,
        S_SETTLE,
        S_HELD
    } scan_state_t;

    localparam logic [3:0] MAX_H2        = 4'd2;
    localparam logic [3:0] MAX_H1_POST20 = 4'd3;
    localparam logic [3:0] MAX_M2        = 4'd5;
    localparam logic [3:0] MAX_UNITS     = 4'd9;

    function automatic logic time_is_legal(input logic [3:0] h2, input logic [3:0] h1,
                                           input logic [3:0] m2, input logic [3:0] m1);
        return (h2 <= MAX_H2) && (h1 <= MAX_UNITS) &&
               !((h2 == MAX_H2) && (h1 > MAX_H1_POST20)) &&
               (m2 <= MAX_M2) && (m1 <= MAX_UNITS);
    endfunction

endpackage

// File: rtl/ss_scan_decoder_if.sv
// rtl/ss_scan_decoder_if.sv - multiplexed seven-segment scan lines (anodes + cathodes)
interface ss_scan_decoder_if;
    logic [7:0] SegmentDrivers;
    logic [7:0] SevenSegment;

    modport master (output SegmentDrivers, output SevenSegment);
    modport slave  (input  SegmentDrivers, input  SevenSegment);
endinterface

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - combinational active-low a..g glyph to {valid, bcd} lookup
module seg7_to_bcd
    import wallclock_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] bcd
);

    always_comb begin
        valid = 1'b1;
        bcd   = 4'd0;
        case (seg)
            SEG_0[6:0]: bcd = 4'd0;
            SEG_1[6:0]: bcd = 4'd1;
            SEG_2[6:0]: bcd = 4'd2;
            SEG_3[6:0]: bcd = 4'd3;
            SEG_4[6:0]: bcd = 4'd4;
            SEG_5[6:0]: bcd = 4'd5;
            SEG_6[6:0]: bcd = 4'd6;
            SEG_7[6:0]: bcd = 4'd7;
            SEG_8[6:0]: bcd = 4'd8;
            SEG_9[6:0]: bcd = 4'd9;
            default:    valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/ss_scan_decoder.sv
// rtl/ss_scan_decoder.sv - rebuilds validated HH:MM from a scanned 7-seg display; SS_DECODE_DP_EN adds dp capture
module ss_scan_decoder
    import wallclock_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CNT_W          = 21
) (
    input  logic               CLK100MHZ,
    input  logic               RESET_N,
    ss_scan_decoder_if.slave   scan,
    output logic [3:0]         hours2,
    output logic [3:0]         hours1,
    output logic [3:0]         mins2,
    output logic [3:0]         mins1,
    output logic [3:0]         dp,
    output logic               time_valid,
    output logic               frame_stb,
    output logic               err
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD    = CNT_W'(TIMEOUT_CYCLES);

    logic        dp_in;
`ifdef SS_DECODE_DP_EN
    assign dp_in = scan.SevenSegment[7];
    wire unused_ok = &{1'b0, scan.SegmentDrivers[7:4]};
`else
    assign dp_in = 1'b1;
    wire unused_ok = &{1'b0, scan.SegmentDrivers[7:4], scan.SevenSegment[7]};
`endif

    // Sample = {anodes[3:0], dp, g..a}; prev holds the one before for the stability compare
    logic [11:0] sync1, sync2, prev;
    always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= {scan.SegmentDrivers[3:0], dp_in, scan.SevenSegment[6:0]};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    logic       present;
    logic [1:0] idx;
    logic       same;
    assign same = (sync2 == prev);

    always_comb begin
        present = 1'b1;
        idx     = DIG_M1;
        case (sync2[11:8])
            4'b1110: idx = DIG_M1;
            4'b1101: idx = DIG_M2;
            4'b1011: idx = DIG_H1;
            4'b0111: idx = DIG_H2;
            default: present = 1'b0;
        endcase
    end

    scan_state_t      state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             capture;

    always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_WAIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        capture  = 1'b0;
        case (state)
            S_WAIT: begin
                if (present) begin
                    state_nx = S_SETTLE;
                    cnt_nx   = CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (!present) begin
                    state_nx = S_WAIT;
                    cnt_nx   = '0;
                end else if (!same) begin
                    cnt_nx = CNT_W'(1);
                end else if (cnt == SETTLE_LAST) begin
                    capture  = 1'b1;
                    state_nx = S_HELD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_HELD: begin
                if (!present) begin
                    state_nx = S_WAIT;
                end else if (!same) begin
                    state_nx = S_SETTLE;
                    cnt_nx   = CNT_W'(1);
                end
            end
            default: begin
                state_nx = S_WAIT;
                cnt_nx   = '0;
            end
        endcase
    end

    logic       glyph_ok;
    logic [3:0] glyph_bcd;
    seg7_to_bcd u_seg7_to_bcd (
        .seg   (sync2[6:0]),
        .valid (glyph_ok),
        .bcd   (glyph_bcd)
    );

    logic             cap_ok, frame_done, legal, reload, tmo_expire;
    logic [3:0]       mask, mask_nx;
    logic [3:0][3:0]  shadow, out_r;
    logic [CNT_W-1:0] tmo;

    assign cap_ok     = capture && glyph_ok;
    assign frame_done = (mask == 4'b1111);
    assign legal      = time_is_legal(shadow[DIG_H2], shadow[DIG_H1], shadow[DIG_M2], shadow[DIG_M1]);
    assign reload     = capture || (frame_done && legal);
    assign tmo_expire = !reload && (tmo == CNT_W'(1));
    // Clear first, then OR in a same-cycle capture so that digit starts the next frame
    assign mask_nx    = ((frame_done || tmo_expire) ? 4'b0000 : mask) |
                        (cap_ok ? (4'b0001 << idx) : 4'b0000);

    always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            mask       <= '0;
            shadow     <= '0;
            out_r      <= '0;
            tmo        <= '0;
            time_valid <= 1'b0;
            frame_stb  <= 1'b0;
            err        <= 1'b0;
        end else begin
            frame_stb <= 1'b0;
            mask      <= mask_nx;
            if (cap_ok)
                shadow[idx] <= glyph_bcd;
            if (capture && !glyph_ok)
                err <= 1'b1;
            if (reload)
                tmo <= TMO_LOAD;
            else if (tmo != '0)
                tmo <= tmo - 1'b1;
            if (frame_done) begin
                if (legal) begin
                    out_r      <= shadow;
                    frame_stb  <= 1'b1;
                    time_valid <= 1'b1;
                end else begin
                    err        <= 1'b1;
                    time_valid <= 1'b0;
                end
            end else if (tmo_expire) begin
                time_valid <= 1'b0;
            end
        end
    end

`ifdef SS_DECODE_DP_EN
    logic [3:0] shadow_dp, dp_r;
    always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            shadow_dp <= '0;
            dp_r      <= '0;
        end else begin
            if (cap_ok)
                shadow_dp[idx] <= ~sync2[7];
            if (frame_done && legal)
                dp_r <= shadow_dp;
        end
    end
    assign dp = dp_r;
`else
    assign dp = 4'b0000;
`endif

    assign hours2 = out_r[DIG_H2];
    assign hours1 = out_r[DIG_H1];
    assign mins2  = out_r[DIG_M2];
    assign mins1  = out_r[DIG_M1];

endmodule

// File: tb/tb_ss_scan_decoder.sv
// tb/tb_ss_scan_decoder.sv - randomized scan stimulus checked against a dwell-level display model
module tb_ss_scan_decoder;

    localparam int STABLE = 16;
    localparam int TMO    = 400;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ss_scan_decoder_if scan ();
    logic [3:0] hours2, hours1, mins2, mins1, dp;
    logic       time_valid, frame_stb, err;

    ss_scan_decoder #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (21)
    ) dut (
        .CLK100MHZ  (clk),
        .RESET_N    (rst_n),
        .scan       (scan),
        .hours2     (hours2),
        .hours1     (hours1),
        .mins2      (mins2),
        .mins1      (mins1),
        .dp         (dp),
        .time_valid (time_valid),
        .frame_stb  (frame_stb),
        .err        (err)
    );

    logic [7:0] glyph_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int stb_cyc  = 0;
    int stb_count = 0;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (frame_stb) begin stb_count++; stb_cyc = cyc; end

    // Display model: shadow digits, mask, published time, flags
    logic [3:0] m_sh [4];
    logic [3:0] m_out [4];
    logic [3:0] m_dpsh, m_dp, m_mask;
    logic       m_valid, m_err;
    int         m_frames = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_legal();
        int hh, mm;
        hh = 10 * m_sh[3] + m_sh[2];
        mm = 10 * m_sh[1] + m_sh[0];
        return (m_sh[3] <= 2) && (m_sh[2] <= 9) && (m_sh[1] <= 5) && (m_sh[0] <= 9) && (hh <= 23) && (mm <= 59);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin m_sh[k] = 0; m_out[k] = 0; end
        m_dpsh = 0; m_dp = 0; m_mask = 0; m_valid = 0; m_err = 0;
    endtask

    task automatic model_capture(input int idx, input logic [7:0] sg);
        int found;
        logic [7:0] g;
        found = -1;
        for (int i = 0; i < 10; i++) begin
            g = glyph_tab[i];
            if (sg[6:0] == g[6:0]) found = i;
        end
        if (found < 0) begin
            m_err = 1;
        end else begin
            m_sh[idx]   = 4'(found);
            m_dpsh[idx] = ~sg[7];
            m_mask[idx] = 1'b1;
            if (m_mask == 4'hF) begin
                m_mask = 0;
                if (model_legal()) begin
                    for (int k = 0; k < 4; k++) m_out[k] = m_sh[k];
                    m_dp = m_dpsh; m_valid = 1; m_frames++;
                end else begin
                    m_err = 1; m_valid = 0;
                end
            end
        end
    endtask

    // One dwell of a constant (anode, segment) pair for n sampling edges
    task automatic seg_dwell(input logic [7:0] an, input logic [7:0] sg, input int n);
        int idx;
        scan.SegmentDrivers = an;
        scan.SevenSegment   = sg;
        repeat (n) @(posedge clk);
        #1;
        if (n >= STABLE && $countones(~an[3:0]) == 1) begin
            idx = 0;
            for (int k = 0; k < 4; k++) if (!an[k]) idx = k;
            model_capture(idx, sg);
        end
    endtask

    function automatic logic [7:0] anode(input int k);
        logic [7:0] a;
        a = 8'hFF;
        a[k] = 1'b0;
        return a;
    endfunction

    function automatic logic [7:0] glyph(input int d, input logic dp_on);
        logic [7:0] g;
        g = glyph_tab[d];
        g[7] = ~dp_on;
        return g;
    endfunction

    task automatic scan_frame(input int d [4], input logic [3:0] dpv, input int ghost, input int hold);
        for (int k = 3; k >= 0; k--) begin
            if (ghost > 0) seg_dwell(anode(k), 8'h80, ghost);
            seg_dwell(anode(k), glyph(d[k], dpv[k]), hold > 0 ? hold : $urandom_range(20, 60));
            if (hold == 0 && $urandom_range(0, 1) == 1) seg_dwell(8'hFF, 8'hFF, $urandom_range(1, 8));
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] exp_dp;
`ifdef SS_DECODE_DP_EN
        exp_dp = m_dp;
`else
        exp_dp = 4'b0000;
`endif
        check({tag, "_time"}, {hours2, hours1, mins2, mins1}, {m_out[3], m_out[2], m_out[1], m_out[0]});
        check({tag, "_valid"}, time_valid, m_valid);
        check({tag, "_err"}, err, m_err);
        check({tag, "_frames"}, stb_count, m_frames);
        check({tag, "_dp"}, dp, exp_dp);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        check({tag, "_rst_time"}, {hours2, hours1, mins2, mins1}, 16'h0000);
        check({tag, "_rst_flags"}, {time_valid, frame_stb, err, dp}, 7'h00);
        scan.SegmentDrivers = 8'hFF;
        scan.SevenSegment   = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int d [4];
        logic [3:0] dpv;
        scan.SegmentDrivers = 8'hFF;
        scan.SevenSegment   = 8'hFF;
        model_reset();
        @(posedge clk);
        #1;
        do_reset("init");

        // 12:34 clean, then with 3-cycle ghosts of glyph 8
        d = '{4, 3, 2, 1};
        scan_frame(d, 4'b0000, 0, 100);
        check_all("basic");
        scan_frame(d, 4'b0000, 3, 100);
        check_all("ghost");

        for (int f = 0; f < 6; f++) begin
            d[3] = $urandom_range(0, 2);
            d[2] = (d[3] == 2) ? $urandom_range(0, 3) : $urandom_range(0, 9);
            d[1] = $urandom_range(0, 5);
            d[0] = $urandom_range(0, 9);
            dpv  = 4'($urandom_range(0, 15));
            scan_frame(d, dpv, $urandom_range(0, 8), 0);
            check_all("rand_legal");
        end

        // Timeout: valid must hold for TMO-1 cycles after frame_stb and drop on the TMO-th
        scan.SegmentDrivers = 8'hFF;
        scan.SevenSegment   = 8'hFF;
        while (cyc < stb_cyc + TMO - 1) @(negedge clk);
        check("tmo_before", time_valid, 1'b1);
        @(negedge clk);
        check("tmo_expired", time_valid, 1'b0);
        m_valid = 0;
        m_mask  = 0;
        @(posedge clk);
        #1;
        check_all("tmo_hold");

        d = '{7, 0, 1, 1};
        scan_frame(d, 4'b0000, 0, 0);
        check_all("relegal");
        d = '{0, 0, 4, 2};
        scan_frame(d, 4'b0000, 0, 30);
        check_all("illegal_2400");

        // Unknown glyph on idx1 blocks the frame until a legal idx1 glyph arrives
        do_reset("unk");
        seg_dwell(anode(1), 8'hFF, 30);
        check("unk_err", err, 1'b1);
        seg_dwell(anode(3), glyph(1, 0), 30);
        seg_dwell(anode(2), glyph(5, 0), 30);
        seg_dwell(anode(0), glyph(7, 0), 30);
        check("unk_noframe", stb_count, m_frames);
        seg_dwell(anode(1), glyph(4, 0), 30);
        check_all("unk_done");

        // Mid-frame reset after mins captured; stale mask/shadow must not leak into 23:59
        do_reset("mid0");
        seg_dwell(anode(1), glyph(4, 0), 30);
        seg_dwell(anode(0), glyph(8, 0), 30);
        do_reset("mid");
        d = '{9, 5, 3, 2};
        scan_frame(d, 4'b0000, 0, 30);
        seg_dwell(anode(0), glyph(9, 0), 2);
        check_all("mid_partial");
        d = '{9, 5, 3, 2};
        scan_frame(d, 4'b0100, 0, 30);
        check_all("mid_2359");

        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 4; k++) d[k] = $urandom_range(0, 9);
            if ($urandom_range(0, 2) != 0) begin
                d[3] = $urandom_range(0, 2);
                d[2] = (d[3] == 2) ? $urandom_range(0, 3) : d[2];
                d[1] = $urandom_range(0, 5);
            end
            dpv = 4'($urandom_range(0, 15));
            scan_frame(d, dpv, $urandom_range(0, 8), 0);
            check_all("rand_mix");
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
